// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the accumulator CPU controller and datapath
package cpu_pkg;

  // Opcodes held in the instruction register
  localparam logic [3:0] OP_NOP        = 4'b0000;
  localparam logic [3:0] OP_ADD        = 4'b0001;
  localparam logic [3:0] OP_SUB        = 4'b0010;
  localparam logic [3:0] OP_NOR        = 4'b0011;
  localparam logic [3:0] OP_REG_TO_ACC = 4'b0100;
  localparam logic [3:0] OP_ACC_TO_REG = 4'b0101;
  localparam logic [3:0] OP_JMPZ_REG   = 4'b0110;
  localparam logic [3:0] OP_JMPZ_IMM   = 4'b0111;
  localparam logic [3:0] OP_JMPC_REG   = 4'b1000;
  localparam logic [3:0] OP_UNDEF_9    = 4'b1001;
  localparam logic [3:0] OP_JMPC_IMM   = 4'b1010;
  localparam logic [3:0] OP_SHFL       = 4'b1011;
  localparam logic [3:0] OP_SHFR       = 4'b1100;
  localparam logic [3:0] OP_IMM_TO_ACC = 4'b1101;
  localparam logic [3:0] OP_UNDEF_E    = 4'b1110;
  localparam logic [3:0] OP_HALT       = 4'b1111;

  // Accumulator source select
  localparam logic [1:0] ACC_SRC_ALU = 2'b00;
  localparam logic [1:0] ACC_SRC_REG = 2'b01;
  localparam logic [1:0] ACC_SRC_IMM = 2'b10;

  // PC jump source select
  localparam logic PC_SRC_REG = 1'b0;
  localparam logic PC_SRC_IMM = 1'b1;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_HALT    = 2'b10
  } state_e;

  // True for opcodes whose result comes from the ALU; the opcode doubles as the ALU op code
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
           (op == OP_SHFL) || (op == OP_SHFR);
  endfunction

endpackage

// File: rtl/controller_fsm.sv
// rtl/controller_fsm.sv - fetch/execute sequencer and opcode decoder for the accumulator CPU
module controller_fsm
  import cpu_pkg::*;
(
  input  logic       Clk,
  input  logic       CLB,
  input  logic [3:0] Opcode,
  input  logic       Z,
  input  logic       C,
  output logic       LoadIR,
  output logic       IncPC,
  output logic       SelPC,
  output logic       LoadPC,
  output logic       LoadReg,
  output logic       LoadAcc,
  output logic [1:0] SelAcc,
  output logic [3:0] SelALU
);

  state_e state_q, state_d;

  // State register; reset wins over the decoded next state from any state
  always_ff @(posedge Clk) begin
    if (CLB) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: fetch/execute alternate, HALT opcode parks the machine until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   state_d = ST_EXECUTE;
      ST_EXECUTE: state_d = (Opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_d = ST_HALT;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Output decode: purely combinational from state, opcode and flags; forced idle during reset
  always_comb begin
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = PC_SRC_REG;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = ACC_SRC_ALU;
    SelALU  = 4'b0000;
    if (!CLB) begin
      case (state_q)
        ST_FETCH: begin
          LoadIR = 1'b1;
          IncPC  = 1'b1;
        end
        ST_EXECUTE: begin
          if (is_alu_op(Opcode)) begin
            LoadAcc = 1'b1;
            SelAcc  = ACC_SRC_ALU;
            SelALU  = Opcode;
          end else begin
            case (Opcode)
              OP_REG_TO_ACC: begin
                LoadAcc = 1'b1;
                SelAcc  = ACC_SRC_REG;
              end
              OP_IMM_TO_ACC: begin
                LoadAcc = 1'b1;
                SelAcc  = ACC_SRC_IMM;
              end
              OP_ACC_TO_REG: LoadReg = 1'b1;
              OP_JMPZ_REG: begin
                LoadPC = Z;
                SelPC  = PC_SRC_REG;
              end
              OP_JMPZ_IMM: begin
                LoadPC = Z;
                SelPC  = PC_SRC_IMM;
              end
              OP_JMPC_REG: begin
                LoadPC = C;
                SelPC  = PC_SRC_REG;
              end
              OP_JMPC_IMM: begin
                LoadPC = C;
                SelPC  = PC_SRC_IMM;
              end
              // NOP, HALT and the two undefined codes leave every strobe low
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_fsm.sv
// tb/tb_controller_fsm.sv - table-driven scoreboard bench for controller_fsm
module tb_controller_fsm;

  logic       Clk;
  logic       CLB;
  logic [3:0] Opcode;
  logic       Z;
  logic       C;
  logic       LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0] SelAcc;
  logic [3:0] SelALU;

  controller_fsm dut (
    .Clk(Clk), .CLB(CLB), .Opcode(Opcode), .Z(Z), .C(C),
    .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Output word layout: {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0]}
  localparam logic [11:0] O_ZERO  = 12'b0000_0000_0000;
  localparam logic [11:0] O_FETCH = 12'b1100_0000_0000;
  localparam logic [11:0] O_RACC  = 12'b0000_0101_0000;
  localparam logic [11:0] O_IACC  = 12'b0000_0110_0000;
  localparam logic [11:0] O_AREG  = 12'b0000_1000_0000;
  localparam logic [11:0] O_JREG  = 12'b0001_0000_0000;
  localparam logic [11:0] O_JIMM  = 12'b0011_0000_0000;
  localparam logic [11:0] M_ALL   = 12'hFFF;
  localparam logic [11:0] M_NOSEL = 12'b1101_1111_1111;

  typedef struct {
    logic        clb;
    logic [3:0]  op;
    logic        z;
    logic        c;
    logic [11:0] exp;
    logic [11:0] mask;
    string       name;
  } vec_t;

  typedef struct {
    logic [11:0] exp;
    logic [11:0] mask;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks;
  int   failures;

  function automatic logic [11:0] o_alu(input logic [3:0] op);
    return {8'b0000_0100, op};
  endfunction

  function automatic logic [11:0] act_word();
    return {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, SelALU};
  endfunction

  task automatic add(input logic clb, input logic [3:0] op, input logic z, input logic c,
                     input logic [11:0] exp, input logic [11:0] mask, input string name);
    vec_t v;
    v.clb = clb; v.op = op; v.z = z; v.c = c; v.exp = exp; v.mask = mask; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic clb, input logic [3:0] op, input logic z, input logic c,
                       input logic [11:0] exp, input logic [11:0] mask, input string name);
    sb_t e;
    CLB = clb; Opcode = op; Z = z; C = c;
    e.exp = exp; e.mask = mask; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    sb_t         e;
    logic [11:0] a;
    a = act_word();
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty act=%b", a);
      return;
    end
    e = sb_q.pop_front();
    if ((a & e.mask) !== (e.exp & e.mask)) begin
      failures++;
      $display("FAIL %s act=%b exp=%b mask=%b", e.name, a, e.exp, e.mask);
    end
    checks++;
    if ((IncPC & LoadPC) !== 1'b0 || (LoadAcc & LoadReg) !== 1'b0) begin
      failures++;
      $display("FAIL %s_exclusive act=%b exp=no_overlap", e.name, a);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    CLB = 1'b1; Opcode = 4'b0000; Z = 1'b0; C = 1'b0;

    add(1, 4'b0001, 1, 1, O_ZERO, M_ALL, "reset0");
    add(1, 4'b1111, 1, 1, O_ZERO, M_ALL, "reset1");
    add(0, 4'b0001, 0, 0, O_FETCH, M_ALL, "fetch_after_reset");
    add(0, 4'b0001, 0, 0, o_alu(4'b0001), M_ALL, "add");
    add(0, 4'b0010, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0010, 0, 0, o_alu(4'b0010), M_ALL, "sub");
    add(0, 4'b0011, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0011, 1, 1, o_alu(4'b0011), M_ALL, "nor");
    add(0, 4'b1100, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1100, 0, 0, o_alu(4'b1100), M_ALL, "shfr");
    add(0, 4'b1011, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1011, 0, 0, o_alu(4'b1011), M_ALL, "shfl");
    add(0, 4'b0100, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0100, 0, 0, O_RACC, M_ALL, "reg_to_acc");
    add(0, 4'b1101, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1101, 0, 0, O_IACC, M_ALL, "imm_to_acc");
    add(0, 4'b0101, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0101, 0, 0, O_AREG, M_ALL, "acc_to_reg");
    add(0, 4'b0110, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0110, 0, 1, O_ZERO, M_ALL, "jmpz_reg_z0");
    add(0, 4'b0110, 1, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0110, 1, 0, O_JREG, M_ALL, "jmpz_reg_z1");
    add(0, 4'b0111, 1, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b0111, 1, 0, O_JIMM, M_ALL, "jmpz_imm_z1");
    add(0, 4'b1000, 0, 1, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1000, 0, 1, O_JREG, M_ALL, "jmpc_reg_c1");
    add(0, 4'b1010, 0, 1, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1010, 0, 1, O_JIMM, M_ALL, "jmpc_imm_c1");
    add(0, 4'b1000, 1, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1000, 1, 0, O_ZERO, M_ALL, "jmpc_reg_c0");
    add(0, 4'b1010, 1, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1010, 1, 0, O_ZERO, M_NOSEL, "jmpc_imm_c0");
    add(0, 4'b1111, 1, 1, O_FETCH, M_ALL, "fetch_op_dontcare");
    add(0, 4'b0000, 1, 1, O_ZERO, M_ALL, "nop");
    add(0, 4'b1001, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1001, 1, 1, O_ZERO, M_ALL, "undef_1001");
    add(0, 4'b1110, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1110, 1, 1, O_ZERO, M_ALL, "undef_1110");
    add(0, 4'b1111, 0, 0, O_FETCH, M_ALL, "fetch");
    add(0, 4'b1111, 0, 0, O_ZERO, M_ALL, "halt_exec");
    for (int i = 0; i < 12; i++) begin
      add(0, 4'(i + 1), i[0], i[1], O_ZERO, M_ALL, "halted");
    end
    add(1, 4'b0001, 1, 1, O_ZERO, M_ALL, "reset_from_halt");
    add(0, 4'b0001, 0, 0, O_FETCH, M_ALL, "fetch_after_halt");
    add(0, 4'b0001, 0, 0, o_alu(4'b0001), M_ALL, "add_after_halt");
    add(0, 4'b0010, 0, 0, O_FETCH, M_ALL, "fetch");
    add(1, 4'b0010, 0, 0, O_ZERO, M_ALL, "reset_in_exec");
    add(0, 4'b0101, 0, 0, O_FETCH, M_ALL, "fetch_after_exec_reset");
    add(0, 4'b0101, 0, 0, O_AREG, M_ALL, "acc_to_reg_after_reset");

    foreach (vecs[i]) begin
      @(posedge Clk);
      #1;
      drive(vecs[i].clb, vecs[i].op, vecs[i].z, vecs[i].c, vecs[i].exp, vecs[i].mask, vecs[i].name);
      @(negedge Clk);
      check_out();
    end

    // Flag change inside an EXECUTE cycle must show up combinationally
    @(posedge Clk);
    #1;
    drive(0, 4'b0110, 0, 0, O_FETCH, M_ALL, "fetch_mid");
    @(negedge Clk);
    check_out();
    @(posedge Clk);
    #1;
    drive(0, 4'b0110, 0, 0, O_ZERO, M_ALL, "jmpz_mid_z0");
    #1;
    check_out();
    drive(0, 4'b0110, 1, 0, O_JREG, M_ALL, "jmpz_mid_z1");
    @(negedge Clk);
    check_out();

    // Reset asserted mid-FETCH, then released: machine restarts at FETCH
    @(posedge Clk);
    #1;
    drive(1, 4'b0001, 0, 0, O_ZERO, M_ALL, "reset_in_fetch");
    @(negedge Clk);
    check_out();
    @(posedge Clk);
    #1;
    drive(0, 4'b0011, 0, 0, O_FETCH, M_ALL, "fetch_after_fetch_reset");
    @(negedge Clk);
    check_out();
    @(posedge Clk);
    #1;
    drive(0, 4'b0011, 0, 0, o_alu(4'b0011), M_ALL, "nor_after_fetch_reset");
    @(negedge Clk);
    check_out();

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover act=%0d exp=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
